// File: rtl/axi_tgen_m.sv
// axi_tgen_m: AXI4 traffic generator/checker that writes a seeded pattern to a memory window and verifies it
//   aclk/areset       clock, async active-high reset
//   start/stop/mode   run control (rising edge of start launches; stop ends a mode-3 loop)
//   seed              pattern seed, latched at launch
//   aw/w/b/ar/r       AXI4 master channels, one outstanding transaction, all IDs zero
//   busy/done/status  run state; status = {err_cnt != 0, done}
//   err_cnt           saturating error count, first_err_addr = beat address of the first error
module axi_tgen_m #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 64,
    parameter int ID_W = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int BURST_LEN = 16,
    parameter int NUM_BURSTS = 64
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                start,
    input  logic                stop,
    input  logic [1:0]          mode,
    input  logic [31:0]         seed,
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [ID_W-1:0]     awid,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp,
    input  logic [ID_W-1:0]     bid,
    output logic                arvalid,
    input  logic                arready,
    output logic [ADDR_W-1:0]   araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [ID_W-1:0]     arid,
    input  logic                rvalid,
    output logic                rready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic [ID_W-1:0]     rid,
    output logic                busy,
    output logic                done,
    output logic [15:0]         err_cnt,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [1:0]          status
);
    localparam int BYTES = DATA_W / 8;
    localparam int LANES = DATA_W / 32;
    localparam logic [ADDR_W-1:0] BEAT_B = ADDR_W'(BYTES);
    localparam logic [ADDR_W-1:0] BURST_B = ADDR_W'(BURST_LEN * BYTES);
    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);
    localparam logic [31:0] LAST_BURST = 32'(NUM_BURSTS - 1);

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

    state_t state;
    logic start_q;
    logic [1:0] mode_q;
    logic [31:0] seed_q;
    logic [31:0] burst_idx;
    logic [7:0] beat;
    logic [ADDR_W-1:0] burst_addr;
    logic [ADDR_W-1:0] beat_addr;
    logic [DATA_W-1:0] cur_pat;
    logic r_fire;
    logic b_fire;
    logic last_burst;
    logic [1:0] err_inc;
    logic [16:0] err_sum;
    logic [ADDR_W-1:0] err_addr;
    logic unused;

    function automatic logic [DATA_W-1:0] pat(input logic [31:0] a, input logic [31:0] s);
        logic [DATA_W-1:0] p;
        for (int k = 0; k < LANES; k++) p[32*k +: 32] = (a + 32'(4 * k)) ^ s;
        return p;
    endfunction

    assign awaddr = burst_addr;
    assign araddr = burst_addr;
    assign awlen = LAST_BEAT;
    assign arlen = LAST_BEAT;
    assign awsize = 3'($clog2(BYTES));
    assign arsize = 3'($clog2(BYTES));
    assign awburst = 2'b01;
    assign arburst = 2'b01;
    assign awid = '0;
    assign arid = '0;
    assign wstrb = '1;
    // The same per-beat pattern serves as write data and as the read expectation.
    assign cur_pat = pat(beat_addr[31:0], seed_q);
    assign wdata = cur_pat;
    assign status = {err_cnt != 16'd0, done};
    assign unused = ^{bid, rid};

    assign r_fire = state == RD_DATA && rvalid;
    assign b_fire = state == WR_RESP && bvalid;
    assign last_burst = burst_idx == LAST_BURST;
    // A read beat can carry two errors: bad data/response and a misplaced rlast.
    assign err_inc = b_fire ? {1'b0, bresp != 2'b00}
                   : r_fire ? {1'b0, rdata != cur_pat || rresp != 2'b00} + {1'b0, rlast != (beat == LAST_BEAT)}
                   : 2'b00;
    assign err_sum = {1'b0, err_cnt} + {15'b0, err_inc};
    assign err_addr = state == WR_RESP ? burst_addr : beat_addr;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
            start_q <= 1'b0;
            mode_q <= 2'd0;
            seed_q <= 32'd0;
            burst_idx <= 32'd0;
            beat <= 8'd0;
            burst_addr <= BASE_ADDR;
            beat_addr <= BASE_ADDR;
            awvalid <= 1'b0;
            wvalid <= 1'b0;
            wlast <= 1'b0;
            bready <= 1'b0;
            arvalid <= 1'b0;
            rready <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            err_cnt <= 16'd0;
            first_err_addr <= '0;
        end else begin
            start_q <= start;
            if (err_inc != 2'b00) begin
                err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
                if (err_cnt == 16'd0) first_err_addr <= err_addr;
            end
            case (state)
                IDLE, DONE: if (start && !start_q) begin
                    mode_q <= mode;
                    seed_q <= seed;
                    done <= 1'b0;
                    busy <= 1'b1;
                    err_cnt <= 16'd0;
                    first_err_addr <= '0;
                    burst_idx <= 32'd0;
                    burst_addr <= BASE_ADDR;
                    awvalid <= mode != 2'd2;
                    arvalid <= mode == 2'd2;
                    state <= mode == 2'd2 ? RD_ADDR : WR_ADDR;
                end
                WR_ADDR: if (awready) begin
                    awvalid <= 1'b0;
                    wvalid <= 1'b1;
                    wlast <= LAST_BEAT == 8'd0;
                    beat <= 8'd0;
                    beat_addr <= burst_addr;
                    state <= WR_DATA;
                end
                WR_DATA: if (wready) begin
                    if (wlast) begin
                        wvalid <= 1'b0;
                        wlast <= 1'b0;
                        bready <= 1'b1;
                        state <= WR_RESP;
                    end else begin
                        beat <= beat + 8'd1;
                        beat_addr <= beat_addr + BEAT_B;
                        wlast <= beat + 8'd1 == LAST_BEAT;
                    end
                end
                WR_RESP: if (bvalid) begin
                    bready <= 1'b0;
                    if (!last_burst) begin
                        burst_idx <= burst_idx + 32'd1;
                        burst_addr <= burst_addr + BURST_B;
                        awvalid <= 1'b1;
                        state <= WR_ADDR;
                    end else if (mode_q == 2'd1) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        state <= DONE;
                    end else begin
                        burst_idx <= 32'd0;
                        burst_addr <= BASE_ADDR;
                        arvalid <= 1'b1;
                        state <= RD_ADDR;
                    end
                end
                RD_ADDR: if (arready) begin
                    arvalid <= 1'b0;
                    rready <= 1'b1;
                    beat <= 8'd0;
                    beat_addr <= burst_addr;
                    state <= RD_DATA;
                end
                RD_DATA: if (rvalid) begin
                    beat <= beat + 8'd1;
                    beat_addr <= beat_addr + BEAT_B;
                    // Burst end is tracked by beat count; rlast is only checked.
                    if (beat == LAST_BEAT) begin
                        rready <= 1'b0;
                        if (!last_burst) begin
                            burst_idx <= burst_idx + 32'd1;
                            burst_addr <= burst_addr + BURST_B;
                            arvalid <= 1'b1;
                            state <= RD_ADDR;
                        end else if (mode_q == 2'd3 && !stop) begin
                            burst_idx <= 32'd0;
                            burst_addr <= BASE_ADDR;
                            awvalid <= 1'b1;
                            state <= WR_ADDR;
                        end else begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_tgen_m.sv
// tb_axi_tgen_m: table-driven bench for axi_tgen_m against a small AXI memory slave model
module tb_axi_tgen_m;
    localparam logic [63:0] BASE = 64'h1000;
    localparam int BL = 4;
    localparam int NB = 2;

    logic aclk, areset, start, stop;
    logic [1:0] mode;
    logic [31:0] seed;
    logic awvalid, awready, wvalid, wready, wlast, bvalid, bready, arvalid, arready, rvalid, rready, rlast;
    logic [63:0] awaddr, araddr, first_err_addr;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize;
    logic [1:0] awburst, arburst, awid, arid, bid, rid, bresp, rresp, status;
    logic [127:0] wdata, rdata;
    logic [15:0] wstrb, err_cnt;
    logic busy, done;

    axi_tgen_m #(.DATA_W(128), .ADDR_W(64), .ID_W(2), .BASE_ADDR(BASE), .BURST_LEN(BL), .NUM_BURSTS(NB)) dut (
        .aclk(aclk), .areset(areset), .start(start), .stop(stop), .mode(mode), .seed(seed),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awid(awid),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid),
        .busy(busy), .done(done), .err_cnt(err_cnt), .first_err_addr(first_err_addr), .status(status)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] seed;
        bit          bp;
        logic [63:0] flip_addr;
        bit          bad_rlast;
        bit          clr_mem;
        logic [1:0]  bresp;
        logic [15:0] exp_err;
        logic [63:0] exp_first;
        logic [1:0]  exp_status;
        int          exp_wr;
        int          exp_rd;
    } vec_t;

    int checks = 0;
    int errors = 0;

    bit bp, bad_rlast, hold_ar;
    logic [63:0] flip_addr;
    logic [1:0] bresp_inj;
    logic [31:0] seed_exp;
    logic [127:0] mem [8];
    int wr_bursts, rd_bursts, wr_beats, rd_beats, proto_err;

    bit aw_stall, w_stall, ar_stall, wl_hold, b_pend, r_act, aw_f, w_f, b_f, ar_f, r_f;
    logic [63:0] aw_hold, ar_hold, w_base, r_addr, a;
    logic [127:0] w_hold;
    int w_idx, r_beat;

    function automatic logic [127:0] pat(input logic [63:0] ad, input logic [31:0] s);
        logic [127:0] p;
        for (int k = 0; k < 4; k++) p[32*k +: 32] = (ad[31:0] + 32'(4 * k)) ^ s;
        return p;
    endfunction

    function automatic int idx(input logic [63:0] ad);
        return int'((ad - BASE) >> 4) & 7;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory slave: handshakes are taken from pre-edge values, new outputs are driven 1ns after the edge.
    initial begin
        {awready, wready, bvalid, arready, rvalid, rlast} = '0;
        bresp = 2'd0; rresp = 2'd0; bid = 2'd0; rid = 2'd0; rdata = '0;
        {aw_stall, w_stall, ar_stall, b_pend, r_act} = '0;
        w_idx = 0; r_beat = 0;
        forever begin
            @(posedge aclk);
            if (areset) begin
                {aw_stall, w_stall, ar_stall, b_pend, r_act} = '0;
                #1;
                {awready, wready, bvalid, arready, rvalid, rlast} = '0;
            end else begin
                if (aw_stall && (!awvalid || awaddr !== aw_hold)) proto_err++;
                if (w_stall && (!wvalid || wdata !== w_hold || wlast !== wl_hold)) proto_err++;
                if (ar_stall && (!arvalid || araddr !== ar_hold)) proto_err++;
                aw_stall = awvalid && !awready; aw_hold = awaddr;
                w_stall = wvalid && !wready; w_hold = wdata; wl_hold = wlast;
                ar_stall = arvalid && !arready; ar_hold = araddr;
                aw_f = awvalid && awready; w_f = wvalid && wready; b_f = bvalid && bready;
                ar_f = arvalid && arready; r_f = rvalid && rready;
                if (aw_f) begin
                    if (awaddr !== BASE + 64'((wr_bursts % NB) * BL * 16) || awlen !== 8'd3 || awsize !== 3'd4
                        || awburst !== 2'b01 || awid !== 2'd0) proto_err++;
                    w_base = awaddr; w_idx = 0; wr_bursts++;
                end
                if (w_f) begin
                    if (wstrb !== 16'hFFFF || wlast !== (w_idx == BL - 1)
                        || wdata !== pat(w_base + 64'(16 * w_idx), seed_exp)) proto_err++;
                    mem[idx(w_base + 64'(16 * w_idx))] = wdata;
                    w_idx++; wr_beats++;
                    if (wlast) b_pend = 1'b1;
                end
                if (ar_f) begin
                    if (araddr !== BASE + 64'((rd_bursts % NB) * BL * 16) || arlen !== 8'd3 || arsize !== 3'd4
                        || arburst !== 2'b01 || arid !== 2'd0) proto_err++;
                    r_addr = araddr; r_beat = 0; r_act = 1'b1; rd_bursts++;
                end
                if (r_f) begin
                    r_beat++; rd_beats++;
                    if (r_beat == BL) r_act = 1'b0;
                end
                #1;
                awready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                wready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                arready = hold_ar ? 1'b0 : bp ? 1'($urandom_range(0, 1)) : 1'b1;
                if (b_f) bvalid = 1'b0;
                if (b_pend && !bvalid && (!bp || $urandom_range(0, 1) == 1)) begin
                    bvalid = 1'b1; bresp = bresp_inj; b_pend = 1'b0;
                end
                if (r_f) rvalid = 1'b0;
                if (r_act && !rvalid && (!bp || $urandom_range(0, 1) == 1)) begin
                    a = r_addr + 64'(16 * r_beat);
                    rdata = mem[idx(a)] ^ ((flip_addr != 0 && a == flip_addr) ? 128'd1 : 128'd0);
                    rlast = (r_beat == BL - 1) && !bad_rlast;
                    rresp = 2'd0;
                    rvalid = 1'b1;
                end
            end
        end
    end

    task automatic clear_run();
        wr_bursts = 0; rd_bursts = 0; wr_beats = 0; rd_beats = 0; proto_err = 0;
    endtask

    task automatic launch(input logic [1:0] m, input logic [31:0] s, input string name);
        @(negedge aclk);
        mode = m; seed = s; seed_exp = s; start = 1'b1;
        @(negedge aclk);
        chk({name, " launch busy+valid"}, {62'd0, busy, (m == 2'd2) ? arvalid : awvalid}, 64'd3);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge aclk);
            n++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        bp = v.bp; flip_addr = v.flip_addr; bad_rlast = v.bad_rlast; bresp_inj = v.bresp; hold_ar = 1'b0;
        if (v.clr_mem) for (int i = 0; i < 8; i++) mem[i] = '0;
        clear_run();
        launch(v.mode, v.seed, name);
        wait_done();
        chk({name, " done"}, 64'(done), 64'd1);
        chk({name, " busy"}, 64'(busy), 64'd0);
        chk({name, " err_cnt"}, 64'(err_cnt), 64'(v.exp_err));
        chk({name, " first_err_addr"}, first_err_addr, v.exp_first);
        chk({name, " status"}, 64'(status), 64'(v.exp_status));
        chk({name, " write beats"}, 64'(wr_beats), 64'(v.exp_wr));
        chk({name, " read beats"}, 64'(rd_beats), 64'(v.exp_rd));
        chk({name, " protocol violations"}, 64'(proto_err), 64'd0);
    endtask

    vec_t vt [9];

    initial begin
        int n;
        vt[0] = '{2'd0, 32'h0000_0000, 1'b0, 64'h0,    1'b0, 1'b0, 2'd0, 16'd0, 64'h0,    2'b01, 8, 8};
        vt[1] = '{2'd0, 32'h1234_5678, 1'b0, 64'h1030, 1'b0, 1'b0, 2'd0, 16'd1, 64'h1030, 2'b11, 8, 8};
        vt[2] = '{2'd0, 32'hA5A5_A5A5, 1'b1, 64'h0,    1'b0, 1'b0, 2'd0, 16'd0, 64'h0,    2'b01, 8, 8};
        vt[3] = '{2'd1, 32'hCAFE_F00D, 1'b0, 64'h0,    1'b0, 1'b0, 2'd0, 16'd0, 64'h0,    2'b01, 8, 0};
        vt[4] = '{2'd2, 32'hCAFE_F00D, 1'b0, 64'h0,    1'b0, 1'b0, 2'd0, 16'd0, 64'h0,    2'b01, 0, 8};
        vt[5] = '{2'd2, 32'hFFFF_FFFF, 1'b0, 64'h0,    1'b0, 1'b1, 2'd0, 16'd8, 64'h1000, 2'b11, 0, 8};
        vt[6] = '{2'd1, 32'h0000_0000, 1'b0, 64'h0,    1'b0, 1'b0, 2'd2, 16'd2, 64'h1000, 2'b11, 8, 0};
        vt[7] = '{2'd0, 32'h0F0F_0F0F, 1'b0, 64'h0,    1'b1, 1'b0, 2'd0, 16'd2, 64'h1030, 2'b11, 8, 8};
        vt[8] = '{2'd0, 32'hDEAD_BEEF, 1'b1, 64'h1070, 1'b0, 1'b0, 2'd0, 16'd1, 64'h1070, 2'b11, 8, 8};

        for (int i = 0; i < 8; i++) mem[i] = '0;
        areset = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0; seed = 32'd0; seed_exp = 32'd0;
        bp = 1'b0; bad_rlast = 1'b0; hold_ar = 1'b0; flip_addr = 64'h0; bresp_inj = 2'd0;
        clear_run();
        repeat (3) @(negedge aclk);
        chk("reset valids/readies", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
        chk("reset busy/done", 64'({busy, done}), 64'd0);
        chk("reset err_cnt", 64'(err_cnt), 64'd0);
        chk("reset first_err_addr", first_err_addr, 64'd0);
        chk("reset status", 64'(status), 64'd0);
        areset = 1'b0;
        @(negedge aclk);

        for (int i = 0; i < 9; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Mode 3 loop, stop raised during the second pass; every write response is SLVERR.
        bp = 1'b0; flip_addr = 64'h0; bad_rlast = 1'b0; bresp_inj = 2'd2;
        clear_run();
        launch(2'd3, 32'h1357_9BDF, "loop");
        n = 0;
        while (wr_bursts < 3 && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        chk("loop reached pass 2", 64'(wr_bursts >= 3), 64'd1);
        stop = 1'b1;
        wait_done();
        stop = 1'b0;
        chk("loop done", 64'(done), 64'd1);
        chk("loop aw bursts", 64'(wr_bursts), 64'd4);
        chk("loop ar bursts", 64'(rd_bursts), 64'd4);
        chk("loop read beats", 64'(rd_beats), 64'd16);
        chk("loop err_cnt", 64'(err_cnt), 64'd4);
        chk("loop first_err_addr", first_err_addr, 64'h1000);
        chk("loop status", 64'(status), 64'd3);
        chk("loop protocol violations", 64'(proto_err), 64'd0);

        // Saturation: preload the counter near the top while the read address is stalled.
        bresp_inj = 2'd0; hold_ar = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        clear_run();
        launch(2'd2, 32'hFFFF_FFFF, "sat");
        force dut.err_cnt = 16'hFFFA;
        @(negedge aclk);
        release dut.err_cnt;
        hold_ar = 1'b0;
        wait_done();
        chk("sat done", 64'(done), 64'd1);
        chk("sat err_cnt", 64'(err_cnt), 64'hFFFF);
        chk("sat first_err_addr untouched", first_err_addr, 64'd0);
        chk("sat status", 64'(status), 64'd3);

        // Asynchronous reset in the middle of the second write burst, then a clean run.
        bresp_inj = 2'd2;
        clear_run();
        launch(2'd0, 32'h2468_ACE0, "arst");
        n = 0;
        while (!(wvalid && err_cnt != 16'd0) && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        chk("arst reached WR_DATA with error", 64'({wvalid, err_cnt != 16'd0}), 64'd3);
        areset = 1'b1;
        #1;
        chk("arst valids/readies", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
        chk("arst busy/done", 64'({busy, done}), 64'd0);
        chk("arst err_cnt", 64'(err_cnt), 64'd0);
        chk("arst first_err_addr", first_err_addr, 64'd0);
        chk("arst status", 64'(status), 64'd0);
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        run_vec('{2'd0, 32'h2468_ACE0, 1'b0, 64'h0, 1'b0, 1'b0, 2'd0, 16'd0, 64'h0, 2'b01, 8, 8}, "post-arst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
